// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Sized for the default instruction memory; instances may override widths.
package imem_loader_pkg;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int IMEM_DEPTH = 1024;
  localparam int WORD_WIDTH = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_WRITE,
    LD_DONE
  } ld_state_e;
endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembly for the instruction-memory loader.
// Holds the byte index and the partially built word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  last_byte
);

  logic [1:0]            idx_q;
  logic [WORD_WIDTH-1:0] asm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (shift_en) begin
      asm_q[{idx_q, 3'b000} +: 8] <= byte_in;
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word = asm_q;
  assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-link loader: packs a byte stream into words, writes the instruction
// memory and releases the core once the whole image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int MEM_DEPTH  = IMEM_DEPTH,
  parameter int WORD_WIDTH = imem_loader_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, clamp;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  pk_clr, pk_shift, pk_last;
  logic [imem_loader_pkg::WORD_WIDTH-1:0] pk_word;

  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .shift_en  (pk_shift),
    .byte_in   (in_data),
    .word      (pk_word),
    .last_byte (pk_last)
  );

  assign clamp    = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign in_ready = (state_q == LD_LOAD) && !abort;
  assign pk_shift = in_valid && in_ready;
  assign busy     = (state_q == LD_LOAD) || (state_q == LD_WRITE);
  assign done     = (state_q == LD_DONE);
  assign cpu_hold = (state_q != LD_DONE);
  // abort squashes a write that is already registered for this cycle
  assign mem_we    = we_q && !abort;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    pk_clr  = 1'b0;
    unique case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          cnt_d   = clamp;
          addr_d  = '0;
          pk_clr  = 1'b1;
          state_d = (clamp == '0) ? LD_DONE : LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (abort) begin
          pk_clr  = 1'b1;
          state_d = LD_IDLE;
        end else if (pk_shift && pk_last) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {in_data, pk_word[WORD_WIDTH-9:0]};
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (abort) begin
          pk_clr  = 1'b1;
          state_d = LD_IDLE;
        end else if ({1'b0, addr_q} == cnt_q - 1'b1) begin
          state_d = LD_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LD_LOAD;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, random images,
// and hand-written abort, start-while-busy and async-reset sequences.
module tb_imem_loader;
  localparam int AW = 4;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          reset, start, abort, in_valid;
  logic [AW:0]   num_words;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done, cpu_hold;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1;
  logic prev_done = 1'b0;
  int got_addr[$];
  logic [31:0] got_data[$];
  int got_cyc[$];
  logic [31:0] words[$];
  logic [7:0] bytes_q[$];

  typedef struct {
    int num;
    bit gaps;
    int exp_writes;
  } vec_t;
  vec_t tbl[7];

  // Write log observed mid-cycle, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1 && !prev_done) done_cyc = cyc;
    prev_done = (done === 1'b1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic bytes_from_words();
    bytes_q.delete();
    foreach (words[i])
      for (int k = 0; k < 4; k++) bytes_q.push_back(words[i][8*k +: 8]);
  endtask

  task automatic make_image(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    bytes_from_words();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_words = n[AW:0];
    idle(1);
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int nb, input bit gaps);
    logic acc;
    for (int i = from; i < from + nb; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        idle(1);
      end
      in_valid = 1'b1;
      in_data = bytes_q[i];
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) chk("byte_accept", acc, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done", done, 1);
    chk("cpu_hold_done", cpu_hold, 0);
    chk("busy_done", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input int n);
    chk("n_writes", got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      chk("w_addr", got_addr[i], i);
      chk("w_data", got_data[i], words[i]);
    end
  endtask

  task automatic run_vec(input int num, input bit gaps, input int expw);
    int n;
    n = (num < DEPTH) ? num : DEPTH;
    clear_log();
    make_image(n);
    do_start(num);
    chk("busy_after_start", busy, n > 0);
    chk("hold_after_start", cpu_hold, n > 0);
    chk("done_after_start", done, n == 0);
    feed(0, n * 4, gaps);
    wait_done();
    check_log(expw);
    if (expw > 0) chk("last_addr", got_addr[got_addr.size()-1], expw - 1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("ready_in_done", in_ready, 0);
    idle(1);
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2, 1'b1, 2};
    tbl[1] = '{0, 1'b0, 0};
    tbl[2] = '{DEPTH + 5, 1'b0, DEPTH};
    tbl[3] = '{DEPTH, 1'b1, DEPTH};
    tbl[4] = '{1, 1'b0, 1};
    tbl[5] = '{5, 1'b1, 5};
    tbl[6] = '{3, 1'b0, 3};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    num_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cpu_hold", cpu_hold, 1);

    // Known two-instruction image, back-to-back bytes
    clear_log();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    bytes_from_words();
    do_start(2);
    feed(0, 8, 1'b0);
    wait_done();
    check_log(2);
    if (got_cyc.size() == 2) begin
      chk("we_spacing", got_cyc[1] - got_cyc[0], 5);
      chk("done_latency", done_cyc - got_cyc[1], 1);
    end

    foreach (tbl[i]) run_vec(tbl[i].num, tbl[i].gaps, tbl[i].exp_writes);

    for (int r = 0; r < 4; r++) begin
      int num;
      num = $urandom_range(0, DEPTH + 6);
      run_vec(num, 1'($urandom_range(0, 1)), (num < DEPTH) ? num : DEPTH);
    end

    // Abort two bytes into the second word
    clear_log();
    make_image(2);
    do_start(2);
    feed(0, 6, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    chk("we_abort_load", mem_we, 0);
    idle(1);
    abort = 1'b0;
    chk("busy_abort", busy, 0);
    chk("done_abort", done, 0);
    chk("hold_abort", cpu_hold, 1);
    idle(6);
    check_log(1);
    clear_log();
    make_image(1);
    do_start(1);
    feed(0, 4, 1'b0);
    wait_done();
    check_log(1);

    // Abort landing on the WRITE cycle
    clear_log();
    make_image(1);
    do_start(1);
    feed(0, 4, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    chk("we_abort_write", mem_we, 0);
    idle(1);
    abort = 1'b0;
    chk("done_wabort", done, 0);
    chk("busy_wabort", busy, 0);
    idle(3);
    chk("n_writes_wabort", got_addr.size(), 0);

    // start pulsed mid-load is ignored
    clear_log();
    make_image(3);
    do_start(3);
    feed(0, 2, 1'b0);
    start = 1'b1;
    num_words = 1;
    idle(1);
    start = 1'b0;
    feed(2, 10, 1'b0);
    wait_done();
    check_log(3);

    // Asynchronous reset between edges, mid-word
    clear_log();
    make_image(3);
    do_start(3);
    feed(0, 10, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_cpu_hold", cpu_hold, 1);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    chk("n_writes_arst", got_addr.size(), 2);
    chk("busy_after_arst", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
